datapath_regfile: RTL

Register bank directly downstream of the 16-bit shared bus mux. It captures the bus value into the single destination register selected by an encoded write-enable. It also applies increment, clear and ALU-load operations. Its register outputs feed back into the bus mux source inputs and out to memory/ALU; one instance per core.

---
 rtl/datapath_regfile_pkg.sv | 29 ++
 rtl/datapath_regfile_inc_reg.sv | 36 +++
 rtl/datapath_regfile.sv | 110 +++++++++++
 3 files changed

// File: rtl/datapath_regfile_pkg.sv
// rtl/datapath_regfile_pkg.sv - shared widths, wr_sel codes and inc_en bit indices
package datapath_regfile_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 8;

    // Destination codes share numbering with the bus mux read-select codes.
    localparam logic [3:0] WR_NONE = 4'd0;
    localparam logic [3:0] WR_AR   = 4'd1;
    localparam logic [3:0] WR_PC   = 4'd2;
    localparam logic [3:0] WR_DR   = 4'd3;
    localparam logic [3:0] WR_R    = 4'd4;
    localparam logic [3:0] WR_AC   = 4'd5;
    localparam logic [3:0] WR_TR   = 4'd6;
    localparam logic [3:0] WR_R1   = 4'd7;
    localparam logic [3:0] WR_R2   = 4'd8;
    localparam logic [3:0] WR_RI   = 4'd9;
    localparam logic [3:0] WR_RJ   = 4'd10;
    localparam logic [3:0] WR_RK   = 4'd11;
    localparam logic [3:0] WR_R3   = 4'd12;
    localparam logic [3:0] WR_IR   = 4'd13;

    localparam int INC_PC = 0;
    localparam int INC_RI = 1;
    localparam int INC_RJ = 2;
    localparam int INC_RK = 3;
    localparam int INC_AC = 4;

endpackage

// File: rtl/datapath_regfile_inc_reg.sv
// rtl/datapath_regfile_inc_reg.sv - register with load (priority) and wrapping increment
module datapath_regfile_inc_reg #(
    parameter int           W   = 8,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end else if (inc_i) begin
            q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - core register bank fed from the shared bus
module datapath_regfile
    import datapath_regfile_pkg::*;
#(
    parameter int            DW     = DW_DEF,
    parameter int            RW     = RW_DEF,
    parameter logic [RW-1:0] PC_RST = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] bus_in,
    input  logic [3:0]    wr_sel,
    input  logic [4:0]    inc_en,
    input  logic          clr_ac,
    input  logic          alu_we,
    input  logic [DW-1:0] alu_in,
    output logic [RW-1:0] ar,
    output logic [RW-1:0] ir,
    output logic [RW-1:0] pc,
    output logic [RW-1:0] dr,
    output logic [RW-1:0] r,
    output logic [RW-1:0] r1,
    output logic [RW-1:0] r2,
    output logic [RW-1:0] ri,
    output logic [RW-1:0] rj,
    output logic [RW-1:0] rk,
    output logic [RW-1:0] r3,
    output logic [DW-1:0] ac,
    output logic [DW-1:0] tr,
    output logic          z
);

    logic [RW-1:0] bus_lo;
    logic          ac_ld;
    logic [DW-1:0] ac_d;

    logic [RW-1:0] ar_q, ir_q, dr_q, r_q, r1_q, r2_q, r3_q;
    logic [DW-1:0] tr_q;

    assign bus_lo = bus_in[RW-1:0];

    datapath_regfile_inc_reg #(.W(RW), .RST(PC_RST)) u_pc (
        .clk(clk), .rst_n(rst_n), .ld_i(wr_sel == WR_PC), .d_i(bus_lo),
        .inc_i(inc_en[INC_PC]), .q_o(pc)
    );

    datapath_regfile_inc_reg #(.W(RW), .RST('0)) u_ri (
        .clk(clk), .rst_n(rst_n), .ld_i(wr_sel == WR_RI), .d_i(bus_lo),
        .inc_i(inc_en[INC_RI]), .q_o(ri)
    );

    datapath_regfile_inc_reg #(.W(RW), .RST('0)) u_rj (
        .clk(clk), .rst_n(rst_n), .ld_i(wr_sel == WR_RJ), .d_i(bus_lo),
        .inc_i(inc_en[INC_RJ]), .q_o(rj)
    );

    datapath_regfile_inc_reg #(.W(RW), .RST('0)) u_rk (
        .clk(clk), .rst_n(rst_n), .ld_i(wr_sel == WR_RK), .d_i(bus_lo),
        .inc_i(inc_en[INC_RK]), .q_o(rk)
    );

    // Clear and ALU load ride on the load port so they outrank both bus write and increment.
    always_comb begin
        ac_ld = clr_ac || alu_we || (wr_sel == WR_AC);
        ac_d  = bus_in;
        if (clr_ac) begin
            ac_d = '0;
        end else if (alu_we) begin
            ac_d = alu_in;
        end
    end

    datapath_regfile_inc_reg #(.W(DW), .RST('0)) u_ac (
        .clk(clk), .rst_n(rst_n), .ld_i(ac_ld), .d_i(ac_d),
        .inc_i(inc_en[INC_AC]), .q_o(ac)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q <= '0;
            ir_q <= '0;
            dr_q <= '0;
            r_q  <= '0;
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
            tr_q <= '0;
        end else begin
            if (wr_sel == WR_AR) ar_q <= bus_lo;
            if (wr_sel == WR_IR) ir_q <= bus_lo;
            if (wr_sel == WR_DR) dr_q <= bus_lo;
            if (wr_sel == WR_R)  r_q  <= bus_lo;
            if (wr_sel == WR_R1) r1_q <= bus_lo;
            if (wr_sel == WR_R2) r2_q <= bus_lo;
            if (wr_sel == WR_R3) r3_q <= bus_lo;
            if (wr_sel == WR_TR) tr_q <= bus_in;
        end
    end

    assign ar = ar_q;
    assign ir = ir_q;
    assign dr = dr_q;
    assign r  = r_q;
    assign r1 = r1_q;
    assign r2 = r2_q;
    assign r3 = r3_q;
    assign tr = tr_q;
    assign z  = (ac == '0);

endmodule
